// File: rtl/uart_program_loader_pkg.sv
// Shared constants for the UART program loader.
// Holds the receiver and loader state encodings and the default bit timing.
package uart_program_loader_pkg;

  // 50 MHz clock divided down to 115200 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] L_LEN_HI  = 3'd0;
  localparam logic [2:0] L_LEN_LO  = 3'd1;
  localparam logic [2:0] L_DATA_HI = 3'd2;
  localparam logic [2:0] L_DATA_LO = 3'd3;
  localparam logic [2:0] L_DONE    = 3'd4;
  localparam logic [2:0] L_ERROR   = 3'd5;

endpackage

// File: rtl/uart_program_loader_rx_core.sv
// 8N1 serial receiver: synchronizes the line, samples at bit midpoints,
// emits a one-cycle byte_valid or stop_error per received frame.
module uart_rx_core
  import uart_program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] data_byte,
  output logic       stop_error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic             sync_0;
  logic             sync_1;
  logic             rx_prev;
  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic [2:0]       bit_index;
  logic [7:0]       shift;

  // Synchronizer flops idle high so reset never looks like a start bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_0  <= 1'b1;
      sync_1  <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync_0  <= rx;
      sync_1  <= sync_0;
      rx_prev <= sync_1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= RX_IDLE;
      count      <= '0;
      bit_index  <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      data_byte  <= '0;
      stop_error <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      stop_error <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rx_prev && !sync_1) begin
            state <= RX_START;
            count <= '0;
          end
        end
        RX_START: begin
          // A line that is high again at mid start bit was only a glitch.
          if (count == HALF_LAST) begin
            count     <= '0;
            bit_index <= '0;
            state     <= sync_1 ? RX_IDLE : RX_DATA;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (count == BIT_LAST) begin
            count <= '0;
            shift <= {sync_1, shift[7:1]};
            if (bit_index == 3'd7) begin
              state <= RX_STOP;
            end else begin
              bit_index <= bit_index + 3'd1;
            end
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (count == BIT_LAST) begin
            count <= '0;
            state <= RX_IDLE;
            if (sync_1) begin
              byte_valid <= 1'b1;
              data_byte  <= shift;
            end else begin
              stop_error <= 1'b1;
            end
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: receives a length-prefixed program over UART and writes it
// word by word into instruction memory, holding the processor off meanwhile.
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH        = 14,
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int CLKS_PER_BIT      = DEFAULT_CLKS_PER_BIT
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         uart_rx,
  output logic                         mem_write_enable,
  output logic [ADDR_WIDTH-1:0]        mem_address,
  output logic [INSTRUCTION_WIDTH-1:0] mem_data,
  output logic                         loading,
  output logic                         done,
  output logic                         framing_error
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] MAX_WORDS = CW'(1) << ADDR_WIDTH;

  logic          byte_valid;
  logic [7:0]    rx_byte;
  logic          stop_error;
  logic [2:0]    state;
  logic [7:0]    len_hi;
  logic [7:0]    data_hi;
  logic [CW-1:0] word_count;
  logic [CW-1:0] write_index;
  logic [CW-1:0] next_index;
  logic [CW-1:0] clamped_count;
  logic [15:0]   header;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock     (clock),
    .reset     (reset),
    .rx        (uart_rx),
    .byte_valid(byte_valid),
    .data_byte (rx_byte),
    .stop_error(stop_error)
  );

  assign header     = {len_hi, rx_byte};
  assign next_index = write_index + CW'(1);

  // Programs longer than the memory are truncated to its size.
  always_comb begin
    clamped_count = CW'(header);
    if (32'(header) > 32'(MAX_WORDS)) begin
      clamped_count = MAX_WORDS;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= L_LEN_HI;
      len_hi           <= '0;
      data_hi          <= '0;
      word_count       <= '0;
      write_index      <= '0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_data         <= '0;
      loading          <= 1'b0;
      done             <= 1'b0;
      framing_error    <= 1'b0;
    end else begin
      mem_write_enable <= 1'b0;
      if (stop_error) begin
        // A finished program stays valid; anything in flight is abandoned.
        framing_error <= 1'b1;
        if (state != L_DONE) begin
          state   <= L_ERROR;
          loading <= 1'b0;
        end
      end else begin
        case (state)
          L_LEN_HI: begin
            if (byte_valid) begin
              len_hi  <= rx_byte;
              loading <= 1'b1;
              state   <= L_LEN_LO;
            end
          end
          L_LEN_LO: begin
            if (byte_valid) begin
              write_index <= '0;
              word_count  <= clamped_count;
              state       <= (header == 16'd0) ? L_DONE : L_DATA_HI;
            end
          end
          L_DATA_HI: begin
            if (byte_valid) begin
              data_hi <= rx_byte;
              state   <= L_DATA_LO;
            end
          end
          L_DATA_LO: begin
            if (byte_valid) begin
              mem_write_enable <= 1'b1;
              mem_data         <= INSTRUCTION_WIDTH'({data_hi, rx_byte});
              mem_address      <= write_index[ADDR_WIDTH-1:0];
              write_index      <= next_index;
              state            <= (next_index == word_count) ? L_DONE : L_DATA_HI;
            end
          end
          // Entered on the final strobe, so done rises as that strobe clears.
          L_DONE: begin
            loading <= 1'b0;
            done    <= 1'b1;
          end
          L_ERROR: loading <= 1'b0;
          default: state <= L_ERROR;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_program_loader.md
UART_PROGRAM_LOADER -- requirements
Module: uart_program_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 14, width of the instruction-memory write address.
REQ-002 Parameter INSTRUCTION_WIDTH, default 16, width of one instruction word; fixed at 2 bytes.
REQ-003 Parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200 baud).
REQ-004 clock  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 uart_rx  input  1  serial line; idle high; 8N1 format, LSB first.
REQ-007 mem_write_enable  output  1  one-cycle write strobe to instruction memory.
REQ-008 mem_address  output  ADDR_WIDTH  word address for the current write.
REQ-009 mem_data  output  INSTRUCTION_WIDTH  instruction word for the current write.
REQ-010 loading  output  1  high while a program transfer is in progress; the processor is held off while high.
REQ-011 done  output  1  sticky; high after the last word of a program has been written.
REQ-012 framing_error  output  1  sticky; high after any stop bit sampled low.

Function
REQ-013 The rx path SHALL pass uart_rx through a 2-flop synchronizer before any use.
REQ-014 RX states SHALL be RX_IDLE, RX_START, RX_DATA, RX_STOP.
REQ-015 RX_IDLE->RX_START on a synchronized falling edge; RX_START SHALL re-sample at CLKS_PER_BIT/2 and return to RX_IDLE if the line is high (glitch rejection).
REQ-016 RX_DATA SHALL sample 8 bits at CLKS_PER_BIT intervals from the start-bit midpoint, LSB first.
REQ-017 RX_STOP SHALL sample once; if high, pulse byte_valid for 1 cycle with the byte; if low, set framing_error and discard the byte.
REQ-018 Loader states SHALL be L_LEN_HI, L_LEN_LO, L_DATA_HI, L_DATA_LO, L_DONE, L_ERROR.
REQ-019 Stream format: 16-bit word count N (high byte first), then N words, each high byte first.
REQ-020 L_LEN_HI SHALL accept the first byte and raise loading in the next cycle; L_LEN_LO completes N.
REQ-021 N=0 SHALL go directly to L_DONE with no memory writes; N greater than 2^ADDR_WIDTH SHALL be clamped to 2^ADDR_WIDTH.
REQ-022 On the low-byte byte_valid in L_DATA_LO, mem_write_enable SHALL be high in the next cycle with mem_data = {hi, lo} and mem_address = write index (first word at address 0).
REQ-023 Address SHALL increment after each write; when the write count reaches N the FSM SHALL enter L_DONE, drop loading and set done in the same cycle as the final strobe clears.
REQ-024 Address SHALL never wrap; writes stop at index 2^ADDR_WIDTH-1 under clamping.
REQ-025 Any framing_error SHALL move the loader to L_ERROR, drop loading, and assert no further writes.
REQ-026 L_DONE and L_ERROR SHALL ignore further bytes until reset.
REQ-027 mem_address and mem_data SHALL hold their last values when mem_write_enable is low.

Reset
REQ-028 On reset low, all outputs SHALL be 0 within the same cycle; RX state RX_IDLE, loader L_LEN_HI, counters 0, synchronizer flops 1.
REQ-029 Reset asserted mid-byte or mid-program SHALL abandon the transfer; no partial word is ever written.

Structure
REQ-030 A shared package SHALL hold the RX and loader state enumerations and the default CLKS_PER_BIT constant.
REQ-031 The serial receiver SHALL be one sub-module, uart_rx_core (synchronizer, RX FSM, byte_valid/byte/stop_error outputs); the loader FSM and counters stay at top level.

Verification
REQ-032 Send 00 02 12 34 AB CD -> writes 0x1234@0, 0xABCD@1, each 1-cycle strobe; done=1, loading=0.
REQ-033 Send 00 00 -> no strobes; done=1 after 2nd stop bit.
REQ-034 0.3-bit low pulse on idle line -> no byte_valid, state stays L_LEN_HI, loading=0.
REQ-035 Send 00 03 11 22 then a byte with stop bit low -> one write 0x1122@0, framing_error=1, loading=0, no further writes even after valid bytes.
REQ-036 Assert reset during 2nd data byte of 00 01 55 66 -> no write; outputs 0; a resent 00 01 77 88 writes 0x7788@0.
REQ-037 Header FF FF with ADDR_WIDTH=4 -> exactly 16 writes at 0..15, then done=1.
